shake_sequencer: RTL



---
 rtl/shake_pkg.sv | 21 ++
 rtl/blk_ptr_ctrl.sv | 49 ++++
 rtl/shake_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/shake_pkg.sv
// Shared types and constants for the SHAKE256 sponge sequencer.
// Sponge geometry, state-input selects and the sequencer FSM states.
package shake_pkg;

    localparam int RATE_BITS = 1088;
    localparam int CAP_BITS  = 512;

    localparam logic [1:0] SEL_ABSORB = 2'd0;
    localparam logic [1:0] SEL_LOAD   = 2'd1;
    localparam logic [1:0] SEL_FEED   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_START,
        ST_WAIT,
        ST_OUT,
        ST_SQZ
    } state_e;

endpackage

// File: rtl/blk_ptr_ctrl.sv
// Input block buffer bookkeeping: write/read pointers, occupancy
// and a per-entry tag marking the final block of a message.
module blk_ptr_ctrl #(
    parameter int NBLK = 8,
    parameter int AW   = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          push_last,
    input  logic          pop,
    output logic [AW-1:0] wptr,
    output logic [AW-1:0] rptr,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          head_last
);

    localparam logic [AW:0] CNT_FULL = (AW+1)'(NBLK);

    logic [NBLK-1:0] tags;

    // Pointers wrap naturally because NBLK is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            if (push && !pop)
                count <= count + (AW+1)'(1);
            else if (pop && !push)
                count <= count - (AW+1)'(1);
        end
    end

    // Last-block tag travels with each buffer entry.
    always_ff @(posedge clock) begin
        if (push) tags[wptr] <= push_last;
    end

    assign full      = (count == CNT_FULL);
    assign empty     = (count == '0);
    assign head_last = tags[rptr];

endmodule

// File: rtl/shake_sequencer.sv
// SHAKE256 sponge sequencer: buffers padded blocks, runs one
// Keccak-f per block, then squeezes out_len blocks to the consumer.
module shake_sequencer
    import shake_pkg::*;
#(
    parameter int NBLK = 8,
    parameter int AW   = 3,
    parameter int LW   = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          msg_valid,
    input  logic          msg_last,
    input  logic [LW-1:0] out_len,
    output logic          msg_ready,
    output logic          buf_wren,
    output logic [AW-1:0] buf_waddr,
    output logic [AW-1:0] buf_raddr,
    output logic [1:0]    state_sel,
    output logic          perm_start,
    input  logic          perm_done,
    output logic          hash_valid,
    input  logic          hash_ready,
    output logic          busy,
    output logic          full
);

    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);

    state_e        state;
    logic          first;
    logic          last_seen;
    logic          len_taken;
    logic          squeeze;
    logic [LW-1:0] len_q;
    logic [LW-1:0] remaining;

    logic          push;
    logic          pop;
    logic          empty;
    logic          head_last;
    logic [AW:0]   count;

    assign msg_ready = !full && !last_seen;
    assign push      = msg_valid && msg_ready;
    assign buf_wren  = push;
    assign pop       = (state == ST_WAIT) && perm_done && !squeeze;
    assign busy      = (state != ST_IDLE) || !empty;

    blk_ptr_ctrl #(
        .NBLK (NBLK),
        .AW   (AW)
    ) u_ptr (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_last (msg_last),
        .pop       (pop),
        .wptr      (buf_waddr),
        .rptr      (buf_raddr),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .head_last (head_last)
    );

    // Sequencer FSM with registered select, start and valid outputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= ST_IDLE;
            first      <= 1'b1;
            last_seen  <= 1'b0;
            len_taken  <= 1'b0;
            squeeze    <= 1'b0;
            len_q      <= '0;
            remaining  <= '0;
            state_sel  <= SEL_LOAD;
            perm_start <= 1'b0;
            hash_valid <= 1'b0;
        end else begin
            perm_start <= 1'b0;
            if (push && !len_taken) begin
                len_taken <= 1'b1;
                len_q     <= out_len;
            end
            if (push && msg_last) last_seen <= 1'b1;
            unique case (state)
                ST_IDLE: begin
                    if (!empty || push) begin
                        state     <= ST_RD;
                        state_sel <= first ? SEL_LOAD : SEL_ABSORB;
                    end
                end
                ST_RD: begin
                    state      <= ST_START;
                    perm_start <= 1'b1;
                    squeeze    <= 1'b0;
                end
                ST_START: state <= ST_WAIT;
                ST_WAIT: begin
                    if (perm_done) begin
                        if (squeeze) begin
                            state      <= ST_OUT;
                            hash_valid <= 1'b1;
                        end else begin
                            first <= 1'b0;
                            if (head_last) begin
                                state      <= ST_OUT;
                                hash_valid <= 1'b1;
                                remaining  <= (len_q == '0) ? LW'(1) : len_q;
                            end else if (count > CNT_ONE || push) begin
                                state     <= ST_RD;
                                state_sel <= SEL_ABSORB;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end
                    end
                end
                ST_OUT: begin
                    if (hash_ready) begin
                        hash_valid <= 1'b0;
                        remaining  <= remaining - LW'(1);
                        if (remaining == LW'(1)) begin
                            state     <= ST_IDLE;
                            first     <= 1'b1;
                            last_seen <= 1'b0;
                            len_taken <= 1'b0;
                            state_sel <= SEL_LOAD;
                        end else begin
                            state      <= ST_SQZ;
                            state_sel  <= SEL_FEED;
                            perm_start <= 1'b1;
                            squeeze    <= 1'b1;
                        end
                    end
                end
                ST_SQZ: state <= ST_WAIT;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
